// File: rtl/coin_ledger_if.sv
// Bus bundle for coin_ledger: coin/select/return requests in, balance and vend status out.
// o_reject_coin exists only when MAX_BALANCE_CAP_EN is defined.
interface coin_ledger_if #(
    parameter int NUM_COINS  = 3,
    parameter int NUM_ITEMS  = 4,
    parameter int TOTAL_BITS = 31
);
    logic [NUM_COINS-1:0]  i_input_coin;
    logic [NUM_ITEMS-1:0]  i_select_item;
    logic [NUM_COINS-1:0]  i_return_coin;
    logic [TOTAL_BITS-1:0] o_current_total;
    logic [NUM_ITEMS-1:0]  o_available_item;
    logic [NUM_ITEMS-1:0]  o_output_item;
    logic [1:0]            o_state;
`ifdef MAX_BALANCE_CAP_EN
    logic [NUM_COINS-1:0]  o_reject_coin;
`endif

    modport master (
`ifdef MAX_BALANCE_CAP_EN
        input  o_reject_coin,
`endif
        output i_input_coin, i_select_item, i_return_coin,
        input  o_current_total, o_available_item, o_output_item, o_state
    );

    modport slave (
`ifdef MAX_BALANCE_CAP_EN
        output o_reject_coin,
`endif
        input  i_input_coin, i_select_item, i_return_coin,
        output o_current_total, o_available_item, o_output_item, o_state
    );
endinterface

// File: rtl/coin_ledger.sv
// Vending balance ledger: accumulates coins, grants vends, handles coin return.
// Define MAX_BALANCE_CAP_EN to reject insertions that would push the balance above MAX_TOTAL.
module coin_ledger #(
    parameter int NUM_COINS  = 3,
    parameter int NUM_ITEMS  = 4,
    parameter int TOTAL_BITS = 31,
    parameter int MAX_TOTAL  = 5000
) (
    input  logic          clk,
    input  logic          reset_n,
    coin_ledger_if.slave  bus
);
    localparam int SW = TOTAL_BITS + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RETURN = 2'd2
    } state_t;

    function automatic logic [SW-1:0] coin_value(input int idx);
        case (idx)
            0:       coin_value = SW'(100);
            1:       coin_value = SW'(500);
            2:       coin_value = SW'(1000);
            default: coin_value = '0;
        endcase
    endfunction

    function automatic logic [SW-1:0] item_price(input int idx);
        case (idx)
            0:       item_price = SW'(400);
            1:       item_price = SW'(500);
            2:       item_price = SW'(1000);
            3:       item_price = SW'(2000);
            default: item_price = '0;
        endcase
    endfunction

    state_t                state_reg, state_next;
    logic [TOTAL_BITS-1:0] total_reg, total_next;
    logic [NUM_ITEMS-1:0]  out_item_reg, out_item_next;
`ifdef MAX_BALANCE_CAP_EN
    logic [NUM_COINS-1:0]  reject_reg, reject_next;
`endif

    logic [SW-1:0] total_ext, coin_sum, coin_add, ret_val, sel_price, sum_ext;
    logic          vend_ok, coins_ok;

    always_comb begin
        coin_sum  = '0;
        ret_val   = '0;
        sel_price = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (bus.i_input_coin[i])  coin_sum = coin_sum + coin_value(i);
            // ascending scan: the highest asserted return bit wins
            if (bus.i_return_coin[i]) ret_val  = coin_value(i);
        end
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (bus.i_select_item[i]) sel_price = item_price(i);
        end
    end

    assign total_ext = {1'b0, total_reg};
    // pre-update total funds the vend, so same-cycle coins cannot pay for it
    assign vend_ok   = (state_reg == ST_HOLD) && $onehot(bus.i_select_item) &&
                       (bus.i_return_coin == '0) && (total_ext >= sel_price);
`ifdef MAX_BALANCE_CAP_EN
    assign coins_ok  = (total_ext + coin_sum) <= SW'(MAX_TOTAL);
`else
    assign coins_ok  = 1'b1;
`endif
    assign coin_add  = coins_ok ? coin_sum : '0;
    assign sum_ext   = total_ext + coin_add - (vend_ok ? sel_price : '0);

    always_comb begin
        state_next    = state_reg;
        total_next    = total_reg;
        out_item_next = '0;
`ifdef MAX_BALANCE_CAP_EN
        reject_next   = '0;
`endif
        if (bus.i_return_coin != '0) begin
            total_next = (ret_val >= total_ext) ? '0 : TOTAL_BITS'(total_ext - ret_val);
            if (state_reg == ST_HOLD)
                state_next = ST_RETURN;
            else if (state_reg == ST_RETURN && ret_val >= total_ext)
                state_next = ST_IDLE;
        end else if (state_reg != ST_RETURN) begin
            total_next    = sum_ext[TOTAL_BITS-1:0];
            out_item_next = vend_ok ? bus.i_select_item : '0;
`ifdef MAX_BALANCE_CAP_EN
            reject_next   = coins_ok ? '0 : bus.i_input_coin;
`endif
            if (state_reg == ST_IDLE && coins_ok && bus.i_input_coin != '0)
                state_next = ST_HOLD;
            else if (state_reg == ST_HOLD && vend_ok && sum_ext[TOTAL_BITS-1:0] == '0)
                state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            total_reg    <= '0;
            out_item_reg <= '0;
`ifdef MAX_BALANCE_CAP_EN
            reject_reg   <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            total_reg    <= total_next;
            out_item_reg <= out_item_next;
`ifdef MAX_BALANCE_CAP_EN
            reject_reg   <= reject_next;
`endif
        end
    end

    assign bus.o_current_total = total_reg;
    assign bus.o_output_item   = out_item_reg;
    assign bus.o_state         = state_reg;
`ifdef MAX_BALANCE_CAP_EN
    assign bus.o_reject_coin   = reject_reg;
`endif

    generate
        for (genvar gi = 0; gi < NUM_ITEMS; gi++) begin : g_avail
            assign bus.o_available_item[gi] = (total_ext >= item_price(gi)) &&
                                              (state_reg != ST_RETURN);
        end
    endgenerate
endmodule

// File: tb/tb_coin_ledger.sv
// Scoreboard bench for coin_ledger: directed steps push hand-computed expectations,
// a monitor pops and compares one entry per clock after the edge.
module tb_coin_ledger;
`ifdef MAX_BALANCE_CAP_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    coin_ledger_if #(.NUM_COINS(3), .NUM_ITEMS(4), .TOTAL_BITS(31)) bus ();

    coin_ledger #(.NUM_COINS(3), .NUM_ITEMS(4), .TOTAL_BITS(31), .MAX_TOTAL(5000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        string       name;
        logic [30:0] total;
        logic [1:0]  st;
        logic [3:0]  out;
        logic [3:0]  avail;
        logic [2:0]  rej;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string nm, input string fld, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
        end
    endtask

    // drive on the falling edge so inputs are stable for the next rising edge
    task automatic step(input string nm, input logic rn, input logic [2:0] c, input logic [3:0] s,
                        input logic [2:0] r, input int t, input logic [1:0] st,
                        input logic [3:0] o, input logic [3:0] av, input logic [2:0] rj);
        exp_t e;
        @(negedge clk);
        reset_n           = rn;
        bus.i_input_coin  = c;
        bus.i_select_item = s;
        bus.i_return_coin = r;
        e.name = nm; e.total = 31'(t); e.st = st; e.out = o; e.avail = av; e.rej = rj;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("txn %s total=%0d state=%0d out=%b avail=%b",
                         e.name, bus.o_current_total, bus.o_state, bus.o_output_item, bus.o_available_item);
                check(e.name, "total", 32'(bus.o_current_total), 32'(e.total));
                check(e.name, "state", 32'(bus.o_state), 32'(e.st));
                check(e.name, "out",   32'(bus.o_output_item), 32'(e.out));
                check(e.name, "avail", 32'(bus.o_available_item), 32'(e.avail));
`ifdef MAX_BALANCE_CAP_EN
                check(e.name, "rej",   32'(bus.o_reject_coin), 32'(e.rej));
`endif
            end
        end
    end

    initial begin : stim
        bus.i_input_coin  = '0;
        bus.i_select_item = '0;
        bus.i_return_coin = '0;
        repeat (2) @(posedge clk);
        //     name          rn  coin    sel      ret     total st  out      avail    rej
        step("reset",        0, 3'b111, 4'b0100, 3'b000,    0, 0, 4'b0000, 4'b0000, 3'b000);
        step("ins500",       1, 3'b010, 4'b0000, 3'b000,  500, 1, 4'b0000, 4'b0011, 3'b000);
        step("ins500b",      1, 3'b010, 4'b0000, 3'b000, 1000, 1, 4'b0000, 4'b0111, 3'b000);
        step("vend2",        1, 3'b000, 4'b0100, 3'b000,    0, 0, 4'b0100, 4'b0000, 3'b000);
        step("pulse_end",    1, 3'b000, 4'b0000, 3'b000,    0, 0, 4'b0000, 4'b0000, 3'b000);
        step("ins500c",      1, 3'b010, 4'b0000, 3'b000,  500, 1, 4'b0000, 4'b0011, 3'b000);
        step("vend0",        1, 3'b000, 4'b0001, 3'b000,  100, 1, 4'b0001, 4'b0000, 3'b000);
        step("multihot",     1, 3'b101, 4'b0000, 3'b000, 1200, 1, 4'b0000, 4'b0111, 3'b000);
        step("vend2b",       1, 3'b000, 4'b0100, 3'b000,  200, 1, 4'b0100, 4'b0000, 3'b000);
        step("ins100",       1, 3'b001, 4'b0000, 3'b000,  300, 1, 4'b0000, 4'b0000, 3'b000);
        step("ins100b",      1, 3'b001, 4'b0000, 3'b000,  400, 1, 4'b0000, 4'b0001, 3'b000);
        step("nofund",       1, 3'b001, 4'b0010, 3'b000,  500, 1, 4'b0000, 4'b0011, 3'b000);
        step("not_onehot",   1, 3'b000, 4'b0011, 3'b000,  500, 1, 4'b0000, 4'b0011, 3'b000);
        step("vend_ins",     1, 3'b001, 4'b0001, 3'b000,  200, 1, 4'b0001, 4'b0000, 3'b000);
        step("reset2",       0, 3'b000, 4'b0000, 3'b000,    0, 0, 4'b0000, 4'b0000, 3'b000);
        step("ins600",       1, 3'b011, 4'b0000, 3'b000,  600, 1, 4'b0000, 4'b0011, 3'b000);
        step("ret_prio",     1, 3'b001, 4'b0001, 3'b010,  100, 2, 4'b0000, 4'b0000, 3'b000);
        step("ret_ignore",   1, 3'b111, 4'b0001, 3'b000,  100, 2, 4'b0000, 4'b0000, 3'b000);
        step("ret_clamp",    1, 3'b000, 4'b0000, 3'b110,    0, 0, 4'b0000, 4'b0000, 3'b000);
        step("ins1100",      1, 3'b101, 4'b0000, 3'b000, 1100, 1, 4'b0000, 4'b0111, 3'b000);
        step("ins1700",      1, 3'b011, 4'b0000, 3'b000, 1700, 1, 4'b0000, 4'b0111, 3'b000);
        step("ret100",       1, 3'b000, 4'b0000, 3'b001, 1600, 2, 4'b0000, 4'b0000, 3'b000);
        step("ret100b",      1, 3'b000, 4'b0000, 3'b001, 1500, 2, 4'b0000, 4'b0000, 3'b000);
        step("reset_ret",    0, 3'b010, 4'b0000, 3'b001,    0, 0, 4'b0000, 4'b0000, 3'b000);
        step("post_reset",   1, 3'b100, 4'b0000, 3'b000, 1000, 1, 4'b0000, 4'b0111, 3'b000);
        step("ins2000",      1, 3'b100, 4'b0000, 3'b000, 2000, 1, 4'b0000, 4'b1111, 3'b000);
        step("ins3000",      1, 3'b100, 4'b0000, 3'b000, 3000, 1, 4'b0000, 4'b1111, 3'b000);
        step("ins4000",      1, 3'b100, 4'b0000, 3'b000, 4000, 1, 4'b0000, 4'b1111, 3'b000);
        step("ins4600",      1, 3'b011, 4'b0000, 3'b000, 4600, 1, 4'b0000, 4'b1111, 3'b000);
        step("cap_ins",      1, 3'b100, 4'b0000, 3'b000, CAP ? 4600 : 5600, 1, 4'b0000, 4'b1111,
             CAP ? 3'b100 : 3'b000);
        step("cap_idle",     1, 3'b000, 4'b0000, 3'b000, CAP ? 4600 : 5600, 1, 4'b0000, 4'b1111, 3'b000);
        step("cap_vend",     1, 3'b100, 4'b1000, 3'b000, CAP ? 2600 : 4600, 1, 4'b1000, 4'b1111,
             CAP ? 3'b100 : 3'b000);
        step("cap_idle2",    1, 3'b000, 4'b0000, 3'b000, CAP ? 2600 : 4600, 1, 4'b0000, 4'b1111, 3'b000);
        repeat (4) @(posedge clk);
        #3;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain actual=%0d required=0 pending entries", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
